// File: rtl/div_result_bcd_if.sv
// Handshake and data bundle between a signed divider and the BCD result converter.
// The slave modport is the converter's view; the master modport is the divider/consumer side.
interface div_result_bcd_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      quotient;
  logic [WIDTH-1:0]      remainder;
  logic                  out_valid;
  logic                  out_ready;
  logic                  q_sign;
  logic [4*DIGITS-1:0]   q_bcd;
  logic                  r_sign;
  logic [4*DIGITS-1:0]   r_bcd;

  modport slave (
    input  in_valid, quotient, remainder, out_ready,
    output in_ready, out_valid, q_sign, q_bcd, r_sign, r_bcd
  );

  modport master (
    output in_valid, quotient, remainder, out_ready,
    input  in_ready, out_valid, q_sign, q_bcd, r_sign, r_bcd
  );
endinterface

// File: rtl/div_result_bcd.sv
// Converts a signed quotient/remainder pair to sign + packed-BCD magnitude using
// WIDTH double-dabble steps on both operands in parallel.
module div_result_bcd #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  div_result_bcd_if.slave     bus
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  q_mag_q, r_mag_q;
  logic [BcdW-1:0]   q_acc_q, r_acc_q;
  logic              q_neg_q, r_neg_q;
  logic              q_sign_q, r_sign_q;
  logic [BcdW-1:0]   q_bcd_q, r_bcd_q;
  logic [BcdW-1:0]   q_step, r_step;

  // |x| as unsigned; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [BcdW-1:0] dabble_step(input logic [BcdW-1:0] acc, input logic in_bit);
    logic [BcdW-1:0] adj;
    adj = acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    return {adj[BcdW-2:0], in_bit};
  endfunction

  assign q_step = dabble_step(q_acc_q, q_mag_q[WIDTH-1]);
  assign r_step = dabble_step(r_acc_q, r_mag_q[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid)       state_d = StConv;
      StConv:  if (cnt_q == LastStep)  state_d = StDone;
      StDone:  if (bus.out_ready)      state_d = StIdle;
      default:                         state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
  end

  assign bus.q_sign = q_sign_q;
  assign bus.q_bcd  = q_bcd_q;
  assign bus.r_sign = r_sign_q;
  assign bus.r_bcd  = r_bcd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      q_mag_q  <= '0;
      r_mag_q  <= '0;
      q_acc_q  <= '0;
      r_acc_q  <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      q_sign_q <= 1'b0;
      r_sign_q <= 1'b0;
      q_bcd_q  <= '0;
      r_bcd_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            q_mag_q <= magnitude(bus.quotient);
            r_mag_q <= magnitude(bus.remainder);
            // A negative value is never zero, so the raw MSB is already the reported sign.
            q_neg_q <= bus.quotient[WIDTH-1];
            r_neg_q <= bus.remainder[WIDTH-1];
            q_acc_q <= '0;
            r_acc_q <= '0;
            cnt_q   <= '0;
          end
        end
        StConv: begin
          q_acc_q <= q_step;
          r_acc_q <= r_step;
          q_mag_q <= {q_mag_q[WIDTH-2:0], 1'b0};
          r_mag_q <= {r_mag_q[WIDTH-2:0], 1'b0};
          cnt_q   <= cnt_q + 1'b1;
          // Outputs only move on DONE entry, so they stay frozen while the consumer stalls.
          if (cnt_q == LastStep) begin
            q_bcd_q  <= q_step;
            r_bcd_q  <= r_step;
            q_sign_q <= q_neg_q;
            r_sign_q <= r_neg_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
